// File: rtl/mips32_ctrl_pkg.sv
// Shared encodings for the Mips32 multi-cycle control unit.
// Optional feature macro: MIPS32_CTRL_JAL_EN (jal decodes to its own state).
package mips32_ctrl_pkg;

    localparam logic [3:0] S_RST_WAIT  = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_I_EXEC    = 4'd11;
    localparam logic [3:0] S_I_WB      = 4'd12;
    localparam logic [3:0] S_JAL       = 4'd13;
    localparam logic [3:0] S_ILLEGAL   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_BREG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       instr_retired;
    } ctrl_word_t;

    // State entered from DECODE for a given opcode.
    function automatic logic [3:0] decode_dispatch(input logic [5:0] opc);
        logic [3:0] nxt;
        case (opc)
            OP_LW, OP_SW:                     nxt = S_MEM_ADDR;
            OP_RTYPE:                         nxt = S_R_EXEC;
            OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
            OP_J:                             nxt = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_I_EXEC;
`ifdef MIPS32_CTRL_JAL_EN
            OP_JAL:                           nxt = S_JAL;
`endif
            default:                          nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips32_ctrl_outdec.sv
// Combinational state+opcode -> control-word decoder for the multi-cycle FSM.
// Optional feature macro: MIPS32_CTRL_JAL_EN (drives the JAL state's controls).
module mips32_ctrl_outdec
    import mips32_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic [ST_W-1:0]  state_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             mem_ready_i,
    output ctrl_word_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.ir_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMMSH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write     = 1'b1;
                ctrl_o.mem_to_reg    = WB_MDR;
                ctrl_o.reg_dst       = DST_RT;
                ctrl_o.instr_retired = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write     = 1'b1;
                ctrl_o.i_or_d        = 1'b1;
                ctrl_o.instr_retired = mem_ready_i;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_BREG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write     = 1'b1;
                ctrl_o.reg_dst       = DST_RD;
                ctrl_o.mem_to_reg    = WB_ALUOUT;
                ctrl_o.instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_BREG;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
                ctrl_o.branch_ne     = (opcode_i == OP_BNE);
                ctrl_o.instr_retired = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write      = 1'b1;
                ctrl_o.pc_src        = PCSRC_JUMP;
                ctrl_o.instr_retired = 1'b1;
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                case (opcode_i)
                    OP_ANDI: ctrl_o.alu_op = ALU_AND;
                    OP_ORI:  ctrl_o.alu_op = ALU_OR;
                    OP_SLTI: ctrl_o.alu_op = ALU_SLT;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                ctrl_o.reg_write     = 1'b1;
                ctrl_o.reg_dst       = DST_RT;
                ctrl_o.mem_to_reg    = WB_ALUOUT;
                ctrl_o.instr_retired = 1'b1;
            end
`ifdef MIPS32_CTRL_JAL_EN
            // PC already holds PC+4 from FETCH, so it is the link value.
            S_JAL: begin
                ctrl_o.pc_write      = 1'b1;
                ctrl_o.pc_src        = PCSRC_JUMP;
                ctrl_o.reg_write     = 1'b1;
                ctrl_o.reg_dst       = DST_RA;
                ctrl_o.mem_to_reg    = WB_PC;
                ctrl_o.instr_retired = 1'b1;
            end
`endif
            S_ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle Mips32 main control FSM: state register and next-state logic.
// Optional feature macro: MIPS32_CTRL_JAL_EN (adds the jal instruction).
module mips32_multicycle_ctrl
    import mips32_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [ST_W-1:0]  state_o,
    output logic             illegal,
    output logic             instr_retired
);

    logic [ST_W-1:0] state_q, state_d;
    ctrl_word_t      ctrl;
    logic            unused_zero;

    // Branch resolution happens in the datapath via pc_write_cond/branch_ne.
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST_WAIT:  state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = decode_dispatch(opcode);
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
`ifdef MIPS32_CTRL_JAL_EN
            S_JAL:       state_d = S_FETCH;
`endif
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_ILLEGAL;
        endcase
    end

    mips32_ctrl_outdec #(
        .OPC_W (OPC_W),
        .ST_W  (ST_W)
    ) u_outdec (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal       = ctrl.illegal;
    assign instr_retired = ctrl.instr_retired;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Self-checking bench for mips32_multicycle_ctrl: per-instruction state paths and
// control words predicted from the instruction rules, with randomized wait states.
module tb_mips32_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_src;
    logic       reg_write, alu_src_a, illegal, instr_retired;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips32_multicycle_ctrl #(
        .OPC_W (6),
        .ST_W  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .state_o       (state_o),
        .illegal       (illegal),
        .instr_retired (instr_retired)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       instr_retired;
    } cw_t;

    cw_t got;
    assign got = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                  illegal, instr_retired};

    // Expected controls for a numbered state, written from the per-state rules.
    function automatic cw_t exp_cw(input int st, input logic [5:0] opc, input logic rdy);
        cw_t c;
        c = '0;
        case (st)
            1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = rdy; c.ir_write = rdy; end
            2:  begin c.alu_src_b = 2'b11; end
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4:  begin c.mem_read = 1; c.i_or_d = 1; end
            5:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; c.instr_retired = 1; end
            6:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_retired = rdy; end
            7:  begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            8:  begin c.reg_write = 1; c.reg_dst = 2'b01; c.instr_retired = 1; end
            9:  begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_src = 2'b01;
                      c.branch_ne = (opc == 6'b000101); c.instr_retired = 1; end
            10: begin c.pc_write = 1; c.pc_src = 2'b10; c.instr_retired = 1; end
            11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10;
                      c.alu_op = (opc == 6'b001100) ? 3'b011 :
                                 (opc == 6'b001101) ? 3'b100 :
                                 (opc == 6'b001010) ? 3'b101 : 3'b000; end
            12: begin c.reg_write = 1; c.instr_retired = 1; end
            13: begin c.pc_write = 1; c.pc_src = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10;
                      c.mem_to_reg = 2'b10; c.instr_retired = 1; end
            14: begin c.illegal = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1 after the last step.
    task automatic run_instr(input logic [5:0] opc, input int unsigned fw, input int unsigned mw,
                             input logic zv, input string tag);
        int   q[$];
        logic r[$];
        int   lat;
        int   retires;
        int   ret_at;
        bit   legal;
        legal   = 1;
        retires = 0;
        ret_at  = -1;
        lat     = 0;
        for (int unsigned k = 0; k < fw; k++) begin q.push_back(1); r.push_back(1'b0); end
        q.push_back(1); r.push_back(1'b1);
        q.push_back(2); r.push_back(1'($urandom));
        case (opc)
            6'b100011: begin
                q.push_back(3); r.push_back(1'($urandom));
                for (int unsigned k = 0; k < mw; k++) begin q.push_back(4); r.push_back(1'b0); end
                q.push_back(4); r.push_back(1'b1);
                q.push_back(5); r.push_back(1'($urandom));
                lat = 5 + int'(mw);
            end
            6'b101011: begin
                q.push_back(3); r.push_back(1'($urandom));
                for (int unsigned k = 0; k < mw; k++) begin q.push_back(6); r.push_back(1'b0); end
                q.push_back(6); r.push_back(1'b1);
                lat = 4 + int'(mw);
            end
            6'b000000: begin q.push_back(7); q.push_back(8); r.push_back(1'($urandom)); r.push_back(1'($urandom)); lat = 4; end
            6'b000100, 6'b000101: begin q.push_back(9); r.push_back(1'($urandom)); lat = 3; end
            6'b000010: begin q.push_back(10); r.push_back(1'($urandom)); lat = 3; end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                q.push_back(11); q.push_back(12); r.push_back(1'($urandom)); r.push_back(1'($urandom)); lat = 4;
            end
`ifdef MIPS32_CTRL_JAL_EN
            6'b000011: begin q.push_back(13); r.push_back(1'($urandom)); lat = 3; end
`endif
            default: begin q.push_back(14); r.push_back(1'($urandom)); legal = 0; end
        endcase
        lat += int'(fw);
        for (int i = 0; i < q.size(); i++) begin
            opcode    = (q[i] == 1) ? 6'($urandom) : opc;
            mem_ready = r[i];
            zero      = zv;
            #1;
            check({tag, "_state"}, {28'd0, state_o}, q[i]);
            check({tag, "_ctrl"}, {10'd0, got}, {10'd0, exp_cw(q[i], opc, r[i])});
            if (instr_retired === 1'b1) begin
                retires++;
                ret_at = i + 1;
            end
            @(posedge clk);
            #1;
        end
        if (legal) begin
            check({tag, "_latency"}, ret_at, lat);
            check({tag, "_retires"}, retires, 1);
        end else begin
            check({tag, "_retires"}, retires, 0);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_async_state", {28'd0, state_o}, 0);
        check("rst_async_ctrl", {10'd0, got}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                   6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

    initial begin
        rst_n     = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_state", {28'd0, state_o}, 0);
            check("reset_ctrl", {10'd0, got}, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(6'b100011, 0, 2, 1'b0, "lw_wait2");
        run_instr(6'b000100, 0, 0, 1'b1, "beq");
        run_instr(6'b000101, 0, 0, 1'b1, "bne");
        run_instr(6'b000000, 0, 0, 1'b0, "rtype");
        run_instr(6'b001000, 0, 0, 1'b0, "addi");
        run_instr(6'b101011, 1, 1, 1'b0, "sw_wait");
        run_instr(6'b000010, 2, 0, 1'b0, "j_fwait");
        run_instr(6'b001100, 0, 0, 1'b0, "andi");
        run_instr(6'b001101, 0, 0, 1'b0, "ori");
        run_instr(6'b001010, 0, 0, 1'b0, "slti");

        for (int n = 0; n < 40; n++) begin
            run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), "rand");
        end

        // Abort in MEM_WB while reg_write is high.
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("midop_state", {28'd0, state_o}, 5);
        check("midop_regwrite", {31'd0, reg_write}, 1);
        #2;
        reset_pulse();
        run_instr(6'b000000, 0, 0, 1'b0, "after_midop");

        run_instr(6'b111111, 0, 0, 1'b0, "illegal_op");
        for (int n = 0; n < 10; n++) begin
            opcode    = 6'($urandom);
            mem_ready = 1'($urandom);
            #1;
            check("illegal_hold_state", {28'd0, state_o}, 14);
            check("illegal_hold_ctrl", {10'd0, got}, {10'd0, exp_cw(14, opcode, mem_ready)});
            @(posedge clk);
            #1;
        end
        reset_pulse();
        run_instr(6'b001000, 0, 0, 1'b0, "after_illegal");

        run_instr(6'b000011, 0, 0, 1'b0, "jal");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
